// File: rtl/tt_seq_divider_hhrb98_if.sv
// Request/result bundle for the 8-bit by 4-bit sequential divider.
// The master side issues operands; the slave side returns registered results.
interface tt_seq_divider_hhrb98_if;
  localparam int unsigned DVD_W = 8;
  localparam int unsigned DVS_W = 4;

  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/tt_seq_divider_hhrb98.sv
// Restoring 8-bit / 4-bit unsigned divider, one quotient bit per clock, MSB first.
// Fixed latency of 8 CALC edges; divide-by-zero returns all-ones with a flag.
module tt_seq_divider_hhrb98 (
  input  logic                    clk,
  input  logic                    rst,
  tt_seq_divider_hhrb98_if.slave  bus
);
  localparam int unsigned DVD_W = 8;
  localparam int unsigned DVS_W = 4;
  localparam int unsigned PR_W  = DVS_W + 1;
  localparam int unsigned CNT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           state,   state_nxt;
  logic [CNT_W-1:0] cnt,     cnt_nxt;
  logic [DVD_W-1:0] dvd,     dvd_nxt;
  logic [DVS_W-1:0] dvs,     dvs_nxt;
  logic [DVS_W-1:0] pr,      pr_nxt;
  logic [DVD_W-1:0] qacc,    qacc_nxt;
  logic [DVD_W-1:0] quot,    quot_nxt;
  logic [DVS_W-1:0] rem,     rem_nxt;
  logic             busy_q,  busy_nxt;
  logic             done_q,  done_nxt;
  logic             dbz_q,   dbz_nxt;

  logic [PR_W-1:0]  pr_sh;
  logic             q_bit;
  logic [DVS_W-1:0] pr_rem;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      pr     <= '0;
      qacc   <= '0;
      quot   <= '0;
      rem    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dvd    <= dvd_nxt;
      dvs    <= dvs_nxt;
      pr     <= pr_nxt;
      qacc   <= qacc_nxt;
      quot   <= quot_nxt;
      rem    <= rem_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      dbz_q  <= dbz_nxt;
    end
  end

  // Next-state, iteration step and result loading
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dvd_nxt   = dvd;
    dvs_nxt   = dvs;
    pr_nxt    = pr;
    qacc_nxt  = qacc;
    quot_nxt  = quot;
    rem_nxt   = rem;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    dbz_nxt   = dbz_q;

    // 5-bit trial value: stored remainder (always < divisor) with next dividend bit
    pr_sh  = {pr, dvd[DVD_W-1]};
    q_bit  = (pr_sh >= PR_W'(dvs));
    pr_rem = q_bit ? DVS_W'(pr_sh - PR_W'(dvs)) : pr_sh[DVS_W-1:0];

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CALC;
          cnt_nxt   = '0;
          dvd_nxt   = bus.dividend;
          dvs_nxt   = bus.divisor;
          pr_nxt    = '0;
          qacc_nxt  = '0;
          busy_nxt  = 1'b1;
        end
      end
      CALC: begin
        dvd_nxt  = {dvd[DVD_W-2:0], 1'b0};
        pr_nxt   = pr_rem;
        qacc_nxt = {qacc[DVD_W-2:0], q_bit};
        cnt_nxt  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DVD_W - 1)) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          if (dvs == '0) begin
            quot_nxt = '1;
            rem_nxt  = '0;
            dbz_nxt  = 1'b1;
          end else begin
            quot_nxt = {qacc[DVD_W-2:0], q_bit};
            rem_nxt  = pr_rem;
            dbz_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.quotient    = quot;
  assign bus.remainder   = rem;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_tt_seq_divider_hhrb98.sv
// Scoreboard bench for tt_seq_divider_hhrb98: directed cases, full operand sweep,
// randomized gaps and ignored starts, mid-division reset.
module tb_tt_seq_divider_hhrb98;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  tt_seq_divider_hhrb98_if bus();

  tt_seq_divider_hhrb98 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t hold;
  int   cyc      = 0;
  int   last_acc = 0;
  bit   has_acc  = 1'b0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division, all-ones quotient on zero divisor
  function automatic exp_t ref_div(input logic [7:0] a, input logic [3:0] b, input int acc);
    exp_t e;
    e.acc = acc;
    if (b == 4'h0) begin
      e.q = 8'hFF;
      e.r = 4'h0;
      e.z = 1'b1;
    end else begin
      e.q = 8'(a / b);
      e.r = 4'(a % b);
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Monitor: result on done, latency, busy window and result hold
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'(bus.done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("latency",     32'(cyc - e.acc),    32'd8);
        check("quotient",    32'(bus.quotient),   32'(e.q));
        check("remainder",   32'(bus.remainder),  32'(e.r));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(e.z));
        hold = e;
      end
    end else if (sb.size() != 0 && cyc > sb[0].acc + 8) begin
      check("done_timeout", 32'(bus.done), 32'd1);
      void'(sb.pop_front());
    end
    check("busy", 32'(bus.busy), 32'(has_acc && cyc >= last_acc && cyc <= last_acc + 7));
    check("hold_quotient",    32'(bus.quotient),    32'(hold.q));
    check("hold_remainder",   32'(bus.remainder),   32'(hold.r));
    check("hold_div_by_zero", 32'(bus.div_by_zero), 32'(hold.z));
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a division on the first edge the model says the block is idle
  task automatic issue(input logic [7:0] a, input logic [3:0] b);
    while (has_acc && (cyc + 1 < last_acc + 9)) begin
      @(posedge clk);
      #1;
    end
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    last_acc     = cyc + 1;
    has_acc      = 1'b1;
    sb.push_back(ref_div(a, b, cyc + 1));
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
  endtask

  // Start pulse while a division is running; must have no effect
  task automatic poke(input logic [7:0] a, input logic [3:0] b);
    if (has_acc && cyc + 1 > last_acc && cyc + 1 <= last_acc + 8) begin
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = 8'($urandom);
      bus.divisor  = 4'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},        32'(bus.busy),        32'd0);
    check({tag, "_done"},        32'(bus.done),        32'd0);
    check({tag, "_quotient"},    32'(bus.quotient),    32'd0);
    check({tag, "_remainder"},   32'(bus.remainder),   32'd0);
    check({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
  endtask

  initial begin
    hold         = '{q: 8'h00, r: 4'h0, z: 1'b0, acc: 0};
    bus.start    = 1'b0;
    bus.dividend = 8'h00;
    bus.divisor  = 4'h0;
    #1;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(8'hC8, 4'h7);
    issue(8'hFF, 4'hF);
    issue(8'h05, 4'h9);
    issue(8'h42, 4'h0);
    issue(8'h0A, 4'h3);

    issue(8'h64, 4'h5);
    wait_cyc(3);
    poke(8'hFF, 4'h1);

    issue(8'h90, 4'h4);
    wait_cyc(3);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    sb.delete();
    has_acc = 1'b0;
    hold    = '{q: 8'h00, r: 4'h0, z: 1'b0, acc: 0};
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(8'h90, 4'h4);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(8'(a), 4'(b));
      end
    end

    for (int i = 0; i < 200; i++) begin
      issue(8'($urandom), 4'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        wait_cyc($urandom_range(0, 6));
        poke(8'($urandom), 4'($urandom));
      end
      if ($urandom_range(0, 3) == 0) wait_cyc(8 + $urandom_range(0, 4));
    end

    wait_cyc(12);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
